// File: rtl/systolic_operand_feeder_pkg.sv
// Shared types and helpers for the systolic operand feeder.
// The skew index helper maps a stream time and lane to a buffer element.
package systolic_pkg;

  localparam int ARRAY_SIZE = 4;
  localparam int DW_IN      = 8;

  typedef enum logic [1:0] {LOAD, CLEAR, STREAM, DONE} feed_state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] idx;
  } skew_idx_t;

  // Element (t - lane) is live only while it falls inside the N-deep operand run.
  function automatic skew_idx_t skew_idx(input int t, input int lane, input int n);
    skew_idx_t r;
    int        d;
    d     = t - lane;
    r.vld = (d >= 0) && (d < n);
    r.idx = r.vld ? 8'(d) : 8'd0;
    return r;
  endfunction

endpackage

// File: rtl/systolic_operand_feeder_skew_lane_sel.sv
// One skewed operand lane: picks element (t - LANE) of its buffer slice or zero.
// One cycle latency from the feeder's next-state/next-t; no backpressure.
module skew_lane_sel
  import systolic_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int LANE = 0,
  parameter int TW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [TW-1:0]   t,
  input  logic [N*DW-1:0] elems,
  output logic [DW-1:0]   lane_dat
);

  skew_idx_t     sel;
  logic [DW-1:0] pick;

  always_comb begin
    sel  = skew_idx(int'(t), LANE, N);
    pick = '0;
    for (int k = 0; k < N; k++) begin
      if (sel.vld && (sel.idx == 8'(k))) pick = elems[k*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lane_dat <= '0;
    else     lane_dat <= en ? pick : '0;
  end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Loads N rows of A and B, then streams them diagonally skewed into an NxN systolic array.
// Skew lanes are registered off next-state; in_ready is low for the whole job after the Nth beat.
module systolic_operand_feeder
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = systolic_pkg::ARRAY_SIZE,
  parameter int DW_IN      = systolic_pkg::DW_IN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ARRAY_SIZE*DW_IN-1:0] in_a_row,
  input  logic [ARRAY_SIZE*DW_IN-1:0] in_b_row,
  output logic [ARRAY_SIZE*DW_IN-1:0] a_skew,
  output logic [ARRAY_SIZE*DW_IN-1:0] b_skew,
  output logic                        array_clr,
  output logic                        busy,
  output logic                        done
);

  localparam int BW     = $clog2(ARRAY_SIZE);
  localparam int TW     = $clog2(3*ARRAY_SIZE-2);
  localparam int T_LAST = 3*ARRAY_SIZE-3;

  feed_state_t   state, state_nxt;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [TW-1:0] t_cnt, t_nxt;

  logic [ARRAY_SIZE*DW_IN-1:0] a_buf [ARRAY_SIZE];
  logic [ARRAY_SIZE*DW_IN-1:0] b_buf [ARRAY_SIZE];
  logic [ARRAY_SIZE*DW_IN-1:0] b_col [ARRAY_SIZE];

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    t_nxt     = '0;
    case (state)
      LOAD: begin
        if (in_valid) begin
          if (beat_cnt == BW'(ARRAY_SIZE-1)) begin
            state_nxt = CLEAR;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat_cnt + 1'b1;
          end
        end
      end
      CLEAR:  state_nxt = STREAM;
      STREAM: begin
        if (t_cnt == TW'(T_LAST)) state_nxt = DONE;
        else                      t_nxt     = t_cnt + 1'b1;
      end
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      beat_cnt <= '0;
      t_cnt    <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
      t_cnt    <= t_nxt;
    end
  end

  // Operand buffers are only written by accepted beats; contents survive until the next job.
  always_ff @(posedge clk) begin
    if ((state == LOAD) && in_valid) begin
      a_buf[beat_cnt] <= in_a_row;
      b_buf[beat_cnt] <= in_b_row;
    end
  end

  assign in_ready  = (state == LOAD);
  assign busy      = (state != LOAD);
  assign array_clr = (state == CLEAR);
  assign done      = (state == DONE);

  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
    for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_elem
      assign b_col[j][k*DW_IN +: DW_IN] = b_buf[k][j*DW_IN +: DW_IN];
    end
  end

  // Lanes are driven from next-state so their registered outputs line up with state/t.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    skew_lane_sel #(.N(ARRAY_SIZE), .DW(DW_IN), .LANE(i), .TW(TW)) u_a_lane (
      .clk      (clk),
      .rst      (rst),
      .en       (state_nxt == STREAM),
      .t        (t_nxt),
      .elems    (a_buf[i]),
      .lane_dat (a_skew[i*DW_IN +: DW_IN])
    );
    skew_lane_sel #(.N(ARRAY_SIZE), .DW(DW_IN), .LANE(i), .TW(TW)) u_b_lane (
      .clk      (clk),
      .rst      (rst),
      .en       (state_nxt == STREAM),
      .t        (t_nxt),
      .elems    (b_col[i]),
      .lane_dat (b_skew[i*DW_IN +: DW_IN])
    );
  end

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder: timeline, skew lanes, backpressure, reset, back-to-back.
module tb_systolic_operand_feeder;

  typedef logic [3:0][3:0][7:0] mat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a_row, in_b_row;
  logic [31:0] a_skew, b_skew;
  logic        array_clr, busy, done;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] ah [10];
  logic [31:0] bh [10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_operand_feeder #(.ARRAY_SIZE(4), .DW_IN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a_row  (in_a_row),
    .in_b_row  (in_b_row),
    .a_skew    (a_skew),
    .b_skew    (b_skew),
    .array_clr (array_clr),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_a(input mat_t a, input int t);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (t - i >= 0 && t - i < 4) r[i*8 +: 8] = a[i][t-i];
    return r;
  endfunction

  function automatic logic [31:0] exp_b(input mat_t b, input int t);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 4; j++)
      if (t - j >= 0 && t - j < 4) r[j*8 +: 8] = b[t-j][j];
    return r;
  endfunction

  task automatic load_job(input mat_t a, input mat_t b, input bit gaps, output int e_cyc);
    int k;
    int g;
    bit ph;
    bit acc;
    k  = 0;
    g  = 0;
    ph = 1'b1;
    while (k < 4 && g < 40) begin
      in_valid = gaps ? ph : 1'b1;
      in_a_row = in_valid ? a[k] : 32'hEEEE_EEEE;
      in_b_row = in_valid ? b[k] : 32'hDDDD_DDDD;
      acc      = in_valid && in_ready;
      step();
      if (acc) k++;
      g++;
      ph = !ph;
    end
    if (k < 4) chk("load_timeout", k, 4);
    e_cyc = cyc;
  endtask

  task automatic stream_check(input mat_t a, input mat_t b, input bit hold, input string tag);
    if (hold) begin
      in_a_row = 32'hEEEE_EEEE;
      in_b_row = 32'hDDDD_DDDD;
    end else begin
      in_valid = 1'b0;
    end
    chk({tag, "_clr"},      array_clr, 1);
    chk({tag, "_clr_busy"}, busy, 1);
    chk({tag, "_clr_rdy"},  in_ready, 0);
    chk({tag, "_clr_a"},    a_skew, 0);
    for (int t = 0; t < 10; t++) begin
      step();
      ah[t] = a_skew;
      bh[t] = b_skew;
      chk($sformatf("%s_a_t%0d", tag, t),    a_skew, exp_a(a, t));
      chk($sformatf("%s_b_t%0d", tag, t),    b_skew, exp_b(b, t));
      chk($sformatf("%s_done_t%0d", tag, t), done, 0);
      chk($sformatf("%s_rdy_t%0d", tag, t),  in_ready, 0);
    end
    step();
    chk({tag, "_done"},   done, 1);
    chk({tag, "_done_a"}, a_skew, 0);
    chk({tag, "_done_b"}, b_skew, 0);
    step();
    chk({tag, "_post_done"}, done, 0);
    chk({tag, "_post_rdy"},  in_ready, 1);
    chk({tag, "_post_busy"}, busy, 0);
  endtask

  // Output-stationary array model fed from the recorded skew lanes.
  task automatic check_c(input mat_t a, input mat_t b, input string tag);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        logic [31:0] c;
        logic [31:0] e;
        c = '0;
        e = '0;
        for (int u = 0; u < 10; u++)
          if (u + j - i >= 0 && u + j - i < 10)
            c += 32'(ah[u][i*8 +: 8]) * 32'(bh[u+j-i][j*8 +: 8]);
        for (int k = 0; k < 4; k++) e += 32'(a[i][k]) * 32'(b[k][j]);
        chk($sformatf("%s_c%0d%0d", tag, i, j), c, e);
      end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    mat_t ai, bi, as, bs, ap, bp, a3, b3;
    int   e1, e2, seen;

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ai[i][j] = (i == j) ? 8'd1 : 8'd0;
        bi[i][j] = 8'(4*i + j + 1);
        as[i][j] = 8'(16*i + j + 1);
        bs[i][j] = 8'(8'h80 + 16*i + j);
        ap[i][j] = 8'(8'h30 + 4*i + j);
        bp[i][j] = 8'(8'hC0 - 4*i - j);
        a3[i][j] = 8'(8'hA0 + 4*i + j);
        b3[i][j] = 8'(8'h50 + 3*i + j);
      end

    // Reset with in_valid asserted must leave the idle state untouched.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_a_row = '0;
    in_b_row = '0;
    repeat (3) step();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_rdy",  in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_clr",  array_clr, 0);
    chk("rst_a",    a_skew, 0);
    chk("rst_b",    b_skew, 0);

    // Identity job: hand-computed lane values plus C = B through the array model.
    load_job(ai, bi, 1'b0, e1);
    stream_check(ai, bi, 1'b0, "id");
    chk("id_a_t0_hand", ah[0], 32'h0000_0001);
    chk("id_b_t0_hand", bh[0], 32'h0000_0001);
    chk("id_b_t3_hand", bh[3], 32'h0407_0A0D);
    chk("id_a_t3_hand", ah[3], 32'h0000_0000);
    check_c(ai, bi, "id");

    // Skew sweep with distinct elements; drain phase must be all-zero.
    load_job(as, bs, 1'b0, e1);
    stream_check(as, bs, 1'b0, "sw");
    chk("sw_a_t4_hand", ah[4], 32'h0000_0000 | {8'h32, 8'h23, 8'h14, 8'h00});
    chk("sw_drain_t7", ah[7] | bh[7], 0);
    chk("sw_drain_t9", ah[9] | bh[9], 0);

    // Backpressure: gapped beats, then garbage held valid across CLEAR and STREAM.
    load_job(ap, bp, 1'b1, e1);
    stream_check(ap, bp, 1'b1, "bp");
    in_valid = 1'b0;
    check_c(ap, bp, "bp");

    // Reset in the middle of the stream: skews clear and no done appears.
    load_job(as, bs, 1'b0, e1);
    in_valid = 1'b0;
    repeat (5) step();
    chk("mr_a_t4", a_skew, exp_a(as, 4));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_a_zero", a_skew, 0);
    chk("mr_b_zero", b_skew, 0);
    chk("mr_rdy",    in_ready, 1);
    chk("mr_busy",   busy, 0);
    seen = 0;
    repeat (15) begin
      step();
      if (done) seen++;
    end
    chk("mr_no_done", seen, 0);
    load_job(ap, bp, 1'b0, e1);
    stream_check(ap, bp, 1'b0, "mr_clean");

    // Back-to-back jobs with in_valid held high across the boundary.
    load_job(ai, bi, 1'b0, e1);
    stream_check(ai, bi, 1'b1, "bb1");
    load_job(a3, b3, 1'b0, e2);
    chk("bb_period", e2 - e1, 16);
    stream_check(a3, b3, 1'b0, "bb2");
    check_c(a3, b3, "bb2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
